uart_echo_engine: RTL
=====================

UART_ECHO_ENGINE -- requirements
Module: uart_echo_engine

Interface
REQ-001 Parameter DBIT, default 8: data word width in bits.
REQ-002 Parameter AW, default 2: internal buffer address width; depth = 2**AW words.
REQ-003 Parameter INC, default 1: addend used by increment mode, truncated to DBIT bits.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port mode, input, 2: 00 increment-echo, 01 pass-echo, 10 invert-echo, 11 manual-step.
REQ-007 Port step_tick, input, 1: one-cycle request pulse, used in manual-step only.
REQ-008 Port rx_empty, input, 1: UART receive FIFO empty flag.
REQ-009 Port r_data, input, DBIT: UART receive FIFO head word (first-word-fall-through).
REQ-010 Port rd_uart, output, 1: one-cycle pop strobe to the receive FIFO.
REQ-011 Port tx_full, input, 1: UART transmit FIFO full flag.
REQ-012 Port w_data, output, DBIT: word offered to the transmit FIFO.
REQ-013 Port wr_uart, output, 1: push strobe to the transmit FIFO.
REQ-014 Port last_data, output, DBIT: most recent raw word captured from r_data.
REQ-015 Port buf_count, output, AW+1: current internal buffer occupancy, 0..2**AW.

Function
REQ-016 The read FSM SHALL have the states IDLE, POP and GAP; rd_uart SHALL be a registered output, 1 only in POP.
REQ-017 IDLE->POP SHALL occur when rx_empty=0, buf_count<2**AW and (mode!=11, or step_pending=1); otherwise the FSM SHALL stay in IDLE.
REQ-018 In POP the block SHALL capture r_data into last_data and push the transformed word into the buffer; POP->GAP SHALL be unconditional.
REQ-019 GAP->IDLE SHALL be unconditional, so at most one pop occurs per 3 cycles and rx_empty has settled before the next decision.
REQ-020 Transform, applied at capture: mode 00 -> r_data+INC modulo 2**DBIT; mode 01 -> r_data; mode 10 -> ~r_data; mode 11 -> r_data+INC.
REQ-021 A mode change SHALL affect only words captured after it; words already buffered SHALL be unchanged.
REQ-022 step_pending SHALL set on step_tick=1 in mode 11 and clear in POP; step_tick while pending, or outside mode 11, SHALL be ignored (no queuing).
REQ-023 Leaving mode 11 SHALL clear step_pending.
REQ-024 w_data SHALL be the buffer head; wr_uart SHALL equal (buf_count!=0) and tx_full=0, combinationally; on wr_uart=1 the head SHALL pop at the clock edge.
REQ-025 A simultaneous push and pop SHALL leave buf_count unchanged and preserve FIFO order.
REQ-026 The buffer SHALL never overflow (the push gate is REQ-017) or underflow (the pop gate is REQ-024); pointers SHALL wrap modulo 2**AW.
REQ-027 Latency: a byte present at IDLE with an empty buffer and tx_full=0 SHALL appear on wr_uart 2 cycles after the IDLE decision edge.

Reset
REQ-028 On reset=1, asynchronously: FSM=IDLE, rd_uart=0, step_pending=0, pointers=0, buf_count=0, last_data=0, and counters=0 when present.
REQ-029 With reset asserted, wr_uart SHALL be 0 because buf_count=0; buffered words SHALL be discarded.
REQ-030 Reset asserted during POP SHALL cancel the push; no partial word SHALL remain.

Configuration
REQ-031 Macro UART_ECHO_STATS_EN, when defined, SHALL add output ports rx_cnt[15:0] (increments on each POP) and tx_cnt[15:0] (increments on each wr_uart=1). Both SHALL wrap 0xFFFF->0 and reset to 0.
REQ-032 When UART_ECHO_STATS_EN is undefined, the ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 mode=00, INC=1, rx FIFO holds 0x41 and tx_full=0 -> one rd_uart pulse, then wr_uart with w_data=0x42, last_data=0x41.
REQ-034 mode=10, rx holds 0xFF, 0x00; mode=00 with INC=1, rx holds 0xFF -> w_data sequence 0x00, 0xFF for the invert case and 0x00 (wrap) for the increment case.
REQ-035 AW=2, tx_full=1, 6 bytes in rx -> exactly 4 rd_uart pulses, buf_count=4, rd_uart held at 0; release tx_full -> remaining 2 bytes read, all 6 written in order.
REQ-036 mode=11, rx holds 3 bytes, two step_tick pulses 1 cycle apart, then one more after 10 cycles -> exactly 2 rd_uart pulses total.
REQ-037 Reset pulsed during POP with buf_count=2 -> rd_uart, buf_count and wr_uart all 0 immediately; with UART_ECHO_STATS_EN defined, rx_cnt=tx_cnt=0.

Source files
------------

// File: rtl/uart_echo_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_echo_engine
// Purpose  : Pops words from a UART receive FIFO (first-word-fall-through),
//            transforms each one according to the selected mode, buffers the
//            results in a small internal FIFO and offers them to a UART
//            transmit FIFO.
//
// Ports    : clk        - sole clock, rising edge
//            reset      - asynchronous, active-high reset
//            mode[1:0]  - 00 increment-echo, 01 pass-echo, 10 invert-echo,
//                         11 manual-step (one word per step_tick)
//            step_tick  - one-cycle step request, honoured in mode 11 only
//            rx_empty   - receive FIFO empty flag
//            r_data     - receive FIFO head word
//            rd_uart    - registered one-cycle pop strobe to the receive FIFO
//            tx_full    - transmit FIFO full flag
//            w_data     - word offered to the transmit FIFO (buffer head)
//            wr_uart    - push strobe to the transmit FIFO
//            last_data  - most recent raw word captured from r_data
//            buf_count  - internal buffer occupancy, 0..2**AW
//            rx_cnt     - words popped from rx     (UART_ECHO_STATS_EN only)
//            tx_cnt     - words pushed to tx       (UART_ECHO_STATS_EN only)
//
// Config   : define UART_ECHO_STATS_EN to add the rx_cnt/tx_cnt statistics
//            ports and counters.
//
// Revision : 1.0 - initial release
// ============================================================================
module uart_echo_engine #(
  parameter int DBIT = 8,
  parameter int AW   = 2,
  parameter int INC  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      mode,
  input  logic            step_tick,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic [DBIT-1:0] w_data,
  output logic            wr_uart,
  output logic [DBIT-1:0] last_data,
`ifdef UART_ECHO_STATS_EN
  output logic [15:0]     rx_cnt,
  output logic [15:0]     tx_cnt,
`endif
  output logic [AW:0]     buf_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int            DEPTH      = 1 << AW;
  localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(DEPTH);
  localparam logic [DBIT-1:0] INC_W    = DBIT'(INC);

  localparam logic [1:0]    MODE_INC   = 2'b00;
  localparam logic [1:0]    MODE_PASS  = 2'b01;
  localparam logic [1:0]    MODE_INV   = 2'b10;
  localparam logic [1:0]    MODE_STEP  = 2'b11;

  localparam logic [1:0]    ST_IDLE    = 2'd0;
  localparam logic [1:0]    ST_POP     = 2'd1;
  localparam logic [1:0]    ST_GAP     = 2'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]      state_q, state_d;
  logic            rd_uart_q;
  logic            step_pending_q, step_pending_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [DBIT-1:0] last_data_q;
  logic [DBIT-1:0] mem_q [DEPTH];

  logic            push_w;
  logic            pop_w;
  logic [DBIT-1:0] xform_w;

  // --------------------------------------------------------------------------
  // Read FSM: IDLE decides, POP captures, GAP lets rx_empty settle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_empty && (count_q < DEPTH_CNT) &&
            ((mode != MODE_STEP) || step_pending_q)) begin
          state_d = ST_POP;
        end
      end
      ST_POP:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Step requests are not queued: a tick only arms an idle request in mode 11.
  // Leaving mode 11 or consuming the request in POP disarms it.
  always_comb begin
    step_pending_d = step_pending_q;
    if (mode != MODE_STEP) begin
      step_pending_d = 1'b0;
    end else if (state_q == ST_POP) begin
      step_pending_d = 1'b0;
    end else if (step_tick) begin
      step_pending_d = 1'b1;
    end
  end

  // Transform is evaluated with the mode in force at capture time, so a mode
  // change never touches words already sitting in the buffer.
  always_comb begin
    xform_w = r_data;
    case (mode)
      MODE_INC:  xform_w = r_data + INC_W;
      MODE_PASS: xform_w = r_data;
      MODE_INV:  xform_w = ~r_data;
      MODE_STEP: xform_w = r_data + INC_W;
      default:   xform_w = r_data;
    endcase
  end

  // --------------------------------------------------------------------------
  // Buffer control
  // --------------------------------------------------------------------------
  // The IDLE gate already guaranteed space; occupancy cannot grow between the
  // decision and POP because only one push happens per three cycles.
  assign push_w = (state_q == ST_POP);
  assign pop_w  = (count_q != '0) && !tx_full;

  always_comb begin
    count_d = count_q;
    case ({push_w, pop_w})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rd_uart_q      <= 1'b0;
      step_pending_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      last_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      // Registered strobe that is high exactly while the FSM sits in POP.
      rd_uart_q      <= (state_d == ST_POP);
      step_pending_q <= step_pending_d;
      count_q        <= count_d;
      if (push_w) begin
        wr_ptr_q    <= wr_ptr_q + AW'(1);
        last_data_q <= r_data;
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Storage needs no reset: occupancy and pointers define which words exist.
  always_ff @(posedge clk) begin
    if (push_w) begin
      mem_q[wr_ptr_q] <= xform_w;
    end
  end

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef UART_ECHO_STATS_EN
  logic [15:0] rx_cnt_q;
  logic [15:0] tx_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (push_w) begin
        rx_cnt_q <= rx_cnt_q + 16'd1;
      end
      if (pop_w) begin
        tx_cnt_q <= tx_cnt_q + 16'd1;
      end
    end
  end

  assign rx_cnt = rx_cnt_q;
  assign tx_cnt = tx_cnt_q;
`endif

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rd_uart   = rd_uart_q;
  assign w_data    = mem_q[rd_ptr_q];
  assign wr_uart   = pop_w;
  assign last_data = last_data_q;
  assign buf_count = count_q;

endmodule
`default_nettype wire
